// File: rtl/ir_command_regs.sv
// ir_command_regs: CPU register window feeding the IR transmitter.
// Builds a held direction command and a one-cycle send trigger.
module ir_command_regs #(
  parameter logic [7:0] BASE_ADDR      = 8'h90,
  parameter int         CLK_FREQ       = 100_000_000,
  parameter int         SEND_RATE_HZ   = 10,
  parameter int         HOLDOFF_CYCLES = 1_500_000,
  parameter int         WDOG_PACKETS   = 10
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic [7:0] BUS_ADDR,
  input  logic [7:0] BUS_DATA_IN,
  input  logic       BUS_WE,
  output logic [7:0] BUS_DATA_OUT,
  output logic       BUS_DATA_OUT_EN,
  output logic [3:0] COMMAND,
  output logic       SEND_PACKET
);

  localparam int PERIOD = CLK_FREQ / SEND_RATE_HZ;
  localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

  localparam logic [TW-1:0] T_LAST = TW'(PERIOD - 1);
  localparam logic [HW-1:0] H_LOAD = HW'(HOLDOFF_CYCLES - 1);
  localparam logic [7:0]    W_LIM  = 8'(WDOG_PACKETS);

  logic [TW-1:0] timer_q, timer_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    cmd_q, cmd_d;
  logic          auto_en_q, auto_en_d;
  logic          wdog_en_q, wdog_en_d;
  logic          req_q, req_d;
  logic          trip_q, trip_d;
  logic [7:0]    pktcnt_q, pktcnt_d;
  logic [7:0]    wcnt_q, wcnt_d;
  logic [3:0]    command_q, command_d;
  logic          send_q, send_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          rden_q, rden_d;

  logic [7:0] off;
  logic       in_win;
  logic [3:0] sel;
  logic       cmd_wr;
  logic       ctrl_wr;
  logic       oneshot_wr;
  logic [7:0] rd_val;
  logic       tick;
  logic       service;
  logic [7:0] wcap;

  always_comb begin
    off        = BUS_ADDR - BASE_ADDR;
    in_win     = off < 8'd4;
    sel        = in_win ? (4'b0001 << off[1:0]) : 4'b0000;
    cmd_wr     = BUS_WE && sel[0];
    ctrl_wr    = BUS_WE && sel[1];
    oneshot_wr = ctrl_wr && BUS_DATA_IN[1];
  end

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      sel[0]:  rd_val = {4'b0000, cmd_q};
      sel[1]:  rd_val = {5'b00000, wdog_en_q, 1'b0, auto_en_q};
      sel[2]:  rd_val = {5'b00000, hold_q != '0, trip_q, req_q};
      sel[3]:  rd_val = pktcnt_q;
      default: rd_val = '0;
    endcase
  end

  always_comb begin
    tick    = timer_q == T_LAST;
    timer_d = tick ? '0 : timer_q + 1'b1;
    service = req_q && (hold_q == '0);

    // a set arriving on the service edge starts a fresh request
    req_d = req_q;
    if (service) req_d = 1'b0;
    if ((tick && auto_en_q) || oneshot_wr) req_d = 1'b1;

    hold_d = hold_q;
    if (service) hold_d = H_LOAD;
    else if (hold_q != '0) hold_d = hold_q - 1'b1;

    send_d    = service;
    command_d = service ? cmd_q : command_q;
    pktcnt_d  = service ? pktcnt_q + 8'd1 : pktcnt_q;

    auto_en_d = ctrl_wr ? BUS_DATA_IN[0] : auto_en_q;
    wdog_en_d = ctrl_wr ? BUS_DATA_IN[2] : wdog_en_q;
  end

  always_comb begin
    wcap   = wdog_en_q ? W_LIM : 8'hFF;
    wcnt_d = wcnt_q;
    if (service && (wcnt_q < wcap)) wcnt_d = wcnt_q + 8'd1;

    // trip on the edge the limit is reached; a CMD write overrides it
    cmd_d  = cmd_q;
    trip_d = trip_q;
    if (wdog_en_q && (wcnt_d >= W_LIM)) begin
      cmd_d  = 4'b0000;
      trip_d = 1'b1;
    end
    if (cmd_wr) begin
      cmd_d  = BUS_DATA_IN[3:0];
      wcnt_d = '0;
      trip_d = 1'b0;
    end
  end

  always_comb begin
    rden_d  = !BUS_WE && in_win;
    rdata_d = rden_d ? rd_val : 8'h00;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      timer_q   <= '0;
      hold_q    <= '0;
      cmd_q     <= '0;
      auto_en_q <= 1'b0;
      wdog_en_q <= 1'b0;
      req_q     <= 1'b0;
      trip_q    <= 1'b0;
      pktcnt_q  <= '0;
      wcnt_q    <= '0;
      command_q <= '0;
      send_q    <= 1'b0;
      rdata_q   <= '0;
      rden_q    <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      hold_q    <= hold_d;
      cmd_q     <= cmd_d;
      auto_en_q <= auto_en_d;
      wdog_en_q <= wdog_en_d;
      req_q     <= req_d;
      trip_q    <= trip_d;
      pktcnt_q  <= pktcnt_d;
      wcnt_q    <= wcnt_d;
      command_q <= command_d;
      send_q    <= send_d;
      rdata_q   <= rdata_d;
      rden_q    <= rden_d;
    end
  end

  assign COMMAND         = command_q;
  assign SEND_PACKET     = send_q;
  assign BUS_DATA_OUT    = rdata_q;
  assign BUS_DATA_OUT_EN = rden_q;

endmodule

// File: tb/tb_ir_command_regs.sv
// tb_ir_command_regs: directed vectors for ir_command_regs.
// PERIOD=10, holdoff 4, watchdog after 3 packets.
module tb_ir_command_regs;

  localparam logic [7:0] A_CMD  = 8'h90;
  localparam logic [7:0] A_CTRL = 8'h91;
  localparam logic [7:0] A_STAT = 8'h92;
  localparam logic [7:0] A_CNT  = 8'h93;

  logic       CLK;
  logic       RESETN;
  logic [7:0] BUS_ADDR;
  logic [7:0] BUS_DATA_IN;
  logic       BUS_WE;
  logic [7:0] BUS_DATA_OUT;
  logic       BUS_DATA_OUT_EN;
  logic [3:0] COMMAND;
  logic       SEND_PACKET;

  ir_command_regs #(
    .BASE_ADDR     (8'h90),
    .CLK_FREQ      (1000),
    .SEND_RATE_HZ  (100),
    .HOLDOFF_CYCLES(4),
    .WDOG_PACKETS  (3)
  ) dut (
    .CLK            (CLK),
    .RESETN         (RESETN),
    .BUS_ADDR       (BUS_ADDR),
    .BUS_DATA_IN    (BUS_DATA_IN),
    .BUS_WE         (BUS_WE),
    .BUS_DATA_OUT   (BUS_DATA_OUT),
    .BUS_DATA_OUT_EN(BUS_DATA_OUT_EN),
    .COMMAND        (COMMAND),
    .SEND_PACKET    (SEND_PACKET)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int np       = 0;
  int wr_edge  = 0;
  bit wide     = 1'b0;
  bit prev_snd = 1'b0;

  // cyc is the number of the last rising edge
  always @(posedge CLK) begin
    #1;
    cyc = cyc + 1;
    if (SEND_PACKET) begin
      np = np + 1;
      if (prev_snd) wide = 1'b1;
    end
    prev_snd = SEND_PACKET;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    BUS_ADDR    = a;
    BUS_DATA_IN = d;
    BUS_WE      = 1'b1;
    wr_edge     = cyc + 1;
    @(negedge CLK);
    BUS_WE      = 1'b0;
    BUS_ADDR    = 8'h00;
    BUS_DATA_IN = 8'h00;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d,
                    output logic en);
    BUS_ADDR = a;
    BUS_WE   = 1'b0;
    @(negedge CLK);
    d        = BUS_DATA_OUT;
    en       = BUS_DATA_OUT_EN;
    BUS_ADDR = 8'h00;
  endtask

  task automatic wait_pulse(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (SEND_PACKET) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check("pulse_timeout", 0, 1);
  endtask

  logic [7:0] d;
  logic       en;
  int         n, p, p0, p1, q, np0;

  initial begin
    RESETN      = 1'b0;
    BUS_ADDR    = 8'h00;
    BUS_DATA_IN = 8'h00;
    BUS_WE      = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_command", COMMAND, 0);
    check("rst_send", SEND_PACKET, 0);
    check("rst_dout", BUS_DATA_OUT, 0);
    check("rst_dout_en", BUS_DATA_OUT_EN, 0);
    RESETN = 1'b1;

    // one-shot latency
    wr(A_CMD, 8'h09);
    wr(A_CTRL, 8'h02);
    n = wr_edge;
    check("os_edge_n", SEND_PACKET, 0);
    @(negedge CLK);
    check("os_cyc", cyc, n + 1);
    check("os_send_n1", SEND_PACKET, 1);
    check("os_cmd_n1", COMMAND, 4'b1001);
    @(negedge CLK);
    check("os_send_n2", SEND_PACKET, 0);
    rd(A_CNT, d, en);
    check("pktcnt_1", d, 1);
    check("pktcnt_1_en", en, 1);
    rd(A_CMD, d, en);
    check("cmd_rb", d, 8'h09);
    rd(A_CTRL, d, en);
    check("ctrl_os_reads0", d, 8'h00);

    // auto send at the rate timer period
    wr(A_CTRL, 8'h01);
    wait_pulse(25, p0);
    check("auto_cmd_old", COMMAND, 4'b1001);
    wr(A_CMD, 8'h06);
    check("cmd_wr_no_change", COMMAND, 4'b1001);
    wait_pulse(25, p1);
    check("auto_gap0", p1 - p0, 10);
    check("auto_cmd_new", COMMAND, 4'b0110);
    p = p1;
    for (int k = 0; k < 4; k++) begin
      p0 = p;
      wait_pulse(25, p);
      check("auto_gap", p - p0, 10);
    end

    // one-shot during holdoff, then tick + one-shot on the same edge
    wr(A_CTRL, 8'h03);
    rd(A_STAT, d, en);
    check("stat_req_hold", d, 8'h05);
    wait_pulse(25, p1);
    check("holdoff_gap", p1 - p, 4);
    wait_pulse(25, q);
    check("tick_after_os", q - p, 10);
    repeat (8) @(negedge CLK);
    wr(A_CTRL, 8'h03);
    wait_pulse(25, p);
    check("merge_first", p - q, 10);
    wait_pulse(25, q);
    check("merge_no_extra", q - p, 10);

    // watchdog
    wr(A_CMD, 8'h05);
    wr(A_CTRL, 8'h05);
    for (int k = 0; k < 3; k++) begin
      wait_pulse(25, p);
      check("wd_cmd_sent", COMMAND, 4'b0101);
    end
    rd(A_STAT, d, en);
    check("wd_stat_trip", d, 8'h06);
    rd(A_CMD, d, en);
    check("wd_cmd_cleared", d, 8'h00);
    wait_pulse(25, p);
    check("wd_4th_cmd", COMMAND, 4'b0000);
    wr(A_CMD, 8'h02);
    rd(A_STAT, d, en);
    check("wd_trip_clr", d, 8'h04);

    // reset mid-holdoff with a request pending
    wait_pulse(25, p);
    check("pre_rst_cmd", COMMAND, 4'b0010);
    wr(A_CTRL, 8'h02);
    RESETN = 1'b0;
    #1;
    check("mid_rst_command", COMMAND, 0);
    check("mid_rst_send", SEND_PACKET, 0);
    check("mid_rst_dout", BUS_DATA_OUT, 0);
    check("mid_rst_dout_en", BUS_DATA_OUT_EN, 0);
    repeat (2) @(negedge CLK);
    RESETN = 1'b1;
    np0 = np;
    repeat (20) @(negedge CLK);
    check("post_rst_no_pulse", np - np0, 0);
    rd(A_CNT, d, en);
    check("post_rst_pktcnt", d, 0);
    rd(A_STAT, d, en);
    check("post_rst_stat", d, 0);

    // ignored writes
    wr(8'h94, 8'h0F);
    rd(A_CMD, d, en);
    check("oow_write_ign", d, 0);
    wr(A_STAT, 8'hFF);
    rd(A_STAT, d, en);
    check("ro_write_ign", d, 0);

    // packet counter wrap
    np0 = np;
    for (int k = 0; k < 255; k++) begin
      wr(A_CTRL, 8'h02);
      repeat (4) @(negedge CLK);
    end
    repeat (3) @(negedge CLK);
    rd(A_CNT, d, en);
    check("pktcnt_255", d, 8'hFF);
    wr(A_CTRL, 8'h02);
    repeat (6) @(negedge CLK);
    rd(A_CNT, d, en);
    check("pktcnt_wrap", d, 8'h00);
    check("wrap_pulses", np - np0, 256);

    rd(8'h94, d, en);
    check("rd_above_en", en, 0);
    check("rd_above_dout", d, 0);
    rd(8'h8F, d, en);
    check("rd_below_en", en, 0);
    wr(A_CTRL, 8'hFD);
    rd(A_CTRL, d, en);
    check("ctrl_mask", d, 8'h05);
    check("pulse_width_1", wide, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
